plic_lite: RTL
==============

Name: plic_lite

Overview:
- Small platform-level interrupt arbiter that sits between up to NUM_SRC external interrupt lines and the core's single machine external interrupt input (mip_external).
- Per source: a level-sensitive gateway, a programmable priority and an enable bit.
- Selects the highest-priority eligible source and drives irq_o.
- Software uses a claim/complete register over a simple single-cycle register bus; the trap handler reads the winning ID, services it, then writes the ID back.

Parameters:
NUM_SRC, 8, number of interrupt sources (IDs 1..NUM_SRC, ID 0 reserved = "none"), legal range 1..31
PRIO_W, 3, priority field width; priority 0 = never interrupts

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
src_i  input  NUM_SRC  level interrupt requests; bit k-1 = source ID k; synchronous to clk_i
req_i  input  1  register access strobe, one access per cycle
we_i  input  1  1 = write, 0 = read
addr_i  input  8  byte address, word aligned (addr_i[1:0] ignored)
wdata_i  input  32  write data
rdata_o  output  32  read data, valid when ack_o=1
ack_o  output  1  access acknowledge, exactly one cycle after req_i
irq_o  output  1  external interrupt request to CSR mip_external

Behaviour:
Reset (rst_i=1 at a clock edge):
- All priorities, the enable bitmap, threshold, pending bits and in-service bits clear to 0.
- irq_o=0, ack_o=0, rdata_o=0.
- Reset mid-operation discards in-service state; no completion is required afterwards.

Register map (word offsets; unmapped read = 0, unmapped write ignored):
- 0x00+4*k: priority[k], k=1..NUM_SRC, bits[PRIO_W-1:0] RW, upper bits read 0. 0x00 (ID 0) reads 0.
- 0x80: pending bitmap RO; bit k = source k. Bit 0 always 0.
- 0x84: enable bitmap RW; bit 0 and bits above NUM_SRC are hardwired 0.
- 0x88: threshold RW, bits[PRIO_W-1:0].
- 0x8C: claim/complete. A read claims; a write completes.

Gateway per source k: three states, IDLE -> PENDING -> INSERVICE -> IDLE.
- IDLE -> PENDING: on an edge where src_i[k]=1.
- PENDING -> INSERVICE: on the edge where a claim read returns k. This clears pending[k].
- INSERVICE -> IDLE: on the edge of a write to 0x8C with wdata_i[4:0]==k.
- While in PENDING or INSERVICE, src_i[k] is ignored. A source still high after completion re-pends on the next edge.
- Pending is not cleared if the source drops or its enable is cleared; it is cleared only by claim.

Arbitration (combinational):
- Eligible: pending[k] & enable[k] & (priority[k] > threshold), strictly greater.
- best_id = eligible source with the highest priority; ties go to the lowest ID. best_id = 0 if none is eligible.
- irq_o is registered: irq_o(n+1) = (best_id(n) != 0).
- Register writes take effect at the edge and are visible to arbitration in the next cycle.

Bus timing:
- Access with req_i=1 in cycle n gives ack_o=1 and rdata_o in cycle n+1.
- Write side effects occur at the end of cycle n.
- Back-to-back accesses are accepted every cycle.
- rdata_o = 0 on writes and when ack_o=0.

Claim:
- A read of 0x8C in cycle n returns best_id(n) zero-extended.
- If nonzero, that source moves to INSERVICE at the end of cycle n. If zero, there is no state change.
- irq_o deasserts in cycle n+1 if no other source is eligible.

Complete:
- A write with ID 0, ID > NUM_SRC, or ID not in INSERVICE is ignored.

Simultaneous events:
- Claim read of k in the same cycle src_i[k] rises: k goes to INSERVICE; the new level is ignored.
- Complete of k while src_i[k]=1: k is IDLE for one edge, then re-pends on the following edge.
- Priority/enable write in the same cycle as a claim: the claim uses pre-write values.

Test Plan:
- Reset; set prio[3]=2, enable=0x08, threshold=0; pulse src_i[2] for 1 cycle -> pending=0x08, irq_o=1 two edges later, stays 1 after src drops.
- prio[2]=5, prio[5]=5, prio[4]=6, all enabled, sources 2,4,5 high -> claim returns 4, then 2 (after completing 4), then 5; irq_o=0 after the last claim plus 1 cycle.
- threshold=5, prio[1]=5, src 1 pending and enabled -> irq_o stays 0, claim reads 0 with no state change. Set threshold=4 -> irq_o=1.
- Claim ID 6 and hold src_i[5]=1 -> no re-pend. Write 0x8C=7 (not in service) -> ignored. Write 0x8C=6 -> pending bit 6 sets again on the next edge.
- Enabled source pending, assert rst_i for one cycle mid-INSERVICE -> all registers read 0, irq_o=0, ack_o=0 the next cycle.
- Back-to-back read 0x84, write 0x88=3, read 0x88 -> ack_o high 3 consecutive cycles, rdata = enable value, 0, 3.

Source files
------------

// File: rtl/plic_lite.sv
// plic_lite: level-gated interrupt arbiter with claim/complete register bus.
// Ports: clk_i/rst_i, src_i lines, req_i/we_i/addr_i/wdata_i -> ack_o/rdata_o, irq_o.
module plic_lite #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic               irq_o
);
    localparam logic [5:0] W_PEND  = 6'h20;
    localparam logic [5:0] W_EN    = 6'h21;
    localparam logic [5:0] W_THR   = 6'h22;
    localparam logic [5:0] W_CLAIM = 6'h23;

    typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_INSVC} gw_e;

    gw_e               gw_q   [NUM_SRC+1];
    gw_e               gw_d   [NUM_SRC+1];
    logic [PRIO_W-1:0] prio_q [NUM_SRC+1];
    logic [PRIO_W-1:0] prio_d [NUM_SRC+1];
    logic [NUM_SRC:0]  en_q, en_d;
    logic [PRIO_W-1:0] thr_q, thr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, irq_q, irq_d;

    logic [5:0]        word;
    logic              rd_acc, wr_acc, claim, cmpl;
    logic [4:0]        cmpl_id;
    logic [NUM_SRC:0]  pend_vec, elig_vec, claim_mask;
    logic [4:0]        best_id;
    logic [PRIO_W-1:0] best_prio;
    logic              unused_ok;

    assign word      = addr_i[7:2];
    assign rd_acc    = req_i & ~we_i;
    assign wr_acc    = req_i & we_i;
    assign claim     = rd_acc && (word == W_CLAIM);
    assign cmpl      = wr_acc && (word == W_CLAIM);
    assign cmpl_id   = wdata_i[4:0];
    assign unused_ok = ^{addr_i[1:0], wdata_i};

    // Strict '>' while scanning upward keeps the lowest ID on a tie.
    always_comb begin : arb
        pend_vec   = '0;
        elig_vec   = '0;
        claim_mask = '0;
        best_id    = '0;
        best_prio  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            pend_vec[k] = (gw_q[k] == GW_PEND);
            elig_vec[k] = pend_vec[k] && en_q[k] && (prio_q[k] > thr_q);
            if (elig_vec[k] && (prio_q[k] > best_prio)) begin
                best_id   = 5'(k);
                best_prio = prio_q[k];
            end
        end
        for (int k = 1; k <= NUM_SRC; k++) begin
            claim_mask[k] = claim && (best_id == 5'(k));
        end
        // The source being claimed no longer holds the line up.
        irq_d = |(elig_vec & ~claim_mask);
    end

    always_comb begin : nxt
        gw_d    = gw_q;
        prio_d  = prio_q;
        en_d    = en_q;
        thr_d   = thr_q;
        rdata_d = '0;
        if (wr_acc) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                if (word == 6'(k)) prio_d[k] = wdata_i[PRIO_W-1:0];
            end
            if (word == W_EN)  en_d  = {wdata_i[NUM_SRC:1], 1'b0};
            if (word == W_THR) thr_d = wdata_i[PRIO_W-1:0];
        end
        if (rd_acc) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                if (word == 6'(k)) rdata_d[PRIO_W-1:0] = prio_q[k];
            end
            case (word)
                W_PEND:  rdata_d[NUM_SRC:0] = pend_vec;
                W_EN:    rdata_d[NUM_SRC:0] = en_q;
                W_THR:   rdata_d[PRIO_W-1:0] = thr_q;
                W_CLAIM: rdata_d[4:0] = best_id;
                default: ;
            endcase
        end
        // Gateways: the line is only looked at while idle.
        for (int k = 1; k <= NUM_SRC; k++) begin
            case (gw_q[k])
                GW_IDLE:  if (src_i[k-1]) gw_d[k] = GW_PEND;
                GW_PEND:  if (claim_mask[k]) gw_d[k] = GW_INSVC;
                GW_INSVC: if (cmpl && cmpl_id == 5'(k)) gw_d[k] = GW_IDLE;
                default:  gw_d[k] = GW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_SRC; k++) begin
                gw_q[k]   <= GW_IDLE;
                prio_q[k] <= '0;
            end
            en_q    <= '0;
            thr_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            gw_q    <= gw_d;
            prio_q  <= prio_d;
            en_q    <= en_d;
            thr_q   <= thr_d;
            rdata_q <= rdata_d;
            ack_q   <= req_i;
            irq_q   <= irq_d;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign irq_o   = irq_q;
endmodule
